shared_resource_arbiter: RTL and testbench

- Requester-side front end for the single-cycle shared compute resource (registered, output = 2 × input, per-requester out_valid tags).
- Arbitrates two pipeline requesters onto the single resource input port and drives the resource's per-requester valid inputs.
- Steers tagged results back into per-requester response FIFOs; stalls a requester via ready when it loses arbitration or lacks response credit.

---
 rtl/shared_resource_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_shared_resource_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
// Requester-side front end for a single-cycle shared compute resource.
// Two requesters compete for the resource input port under round-robin
// arbitration. Each requester has credit-gated access to its own response
// FIFO. Tagged results from the resource are steered back into those FIFOs.
//
// Optional build macro: SHARED_ARB_CHECK_EN
//   When defined, a sticky err output is added. err is raised by a result
//   that has no matching issue, or by both result valids in one cycle.
//   Unexpected results are dropped.
//
// last_grant register:
//   state    | meaning
//   LAST_P1  | port 1 took the most recent accept; port 2 wins the next tie
//   LAST_P2  | port 2 took the most recent accept (reset); port 1 wins the next tie

module shared_resource_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic [DATA_WIDTH-1:0] req_data_1,
  input  logic                  req_valid_2,
  output logic                  req_ready_2,
  input  logic [DATA_WIDTH-1:0] req_data_2,

  output logic                  rsp_valid_1,
  input  logic                  rsp_ready_1,
  output logic [DATA_WIDTH-1:0] rsp_data_1,
  output logic                  rsp_valid_2,
  input  logic                  rsp_ready_2,
  output logic [DATA_WIDTH-1:0] rsp_data_2,

  output logic                  res_in_valid_1,
  output logic                  res_in_valid_2,
  output logic [DATA_WIDTH-1:0] res_input,
  input  logic                  res_out_valid_1,
  input  logic                  res_out_valid_2,
  input  logic [DATA_WIDTH-1:0] res_output
`ifdef SHARED_ARB_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic {
    LAST_P1 = 1'b0,
    LAST_P2 = 1'b1
  } last_grant_e;

  last_grant_e last_grant_q, last_grant_d;

  logic [1:0] req_valid;
  logic [1:0] rsp_ready;
  logic [1:0] res_out_valid;
  logic [1:0] fifo_nonempty;
  logic [1:0] pop;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] wr_en;

  // cnt counts results in flight plus results stored; occ counts stored only
  logic [CW-1:0] cnt_q    [2];
  logic [CW-1:0] cnt_d    [2];
  logic [CW-1:0] occ_q    [2];
  logic [CW-1:0] occ_d    [2];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [DATA_WIDTH-1:0] mem_q [2][RSP_DEPTH];

  assign req_valid     = {req_valid_2, req_valid_1};
  assign rsp_ready     = {rsp_ready_2, rsp_ready_1};
  assign res_out_valid = {res_out_valid_2, res_out_valid_1};

  // Response side: FIFO heads. All outputs are forced low while reset is high.
  assign rsp_valid_1 = fifo_nonempty[0] & ~reset;
  assign rsp_valid_2 = fifo_nonempty[1] & ~reset;
  assign rsp_data_1  = rsp_valid_1 ? mem_q[0][rd_ptr_q[0]] : '0;
  assign rsp_data_2  = rsp_valid_2 ? mem_q[1][rd_ptr_q[1]] : '0;

  // Eligibility: a pop this cycle frees a credit for an accept this cycle
  always_comb begin
    fifo_nonempty = '0;
    pop           = '0;
    elig          = '0;
    for (int p = 0; p < 2; p++) begin
      fifo_nonempty[p] = (occ_q[p] != '0);
      pop[p]  = fifo_nonempty[p] & ~reset & rsp_ready[p];
      elig[p] = req_valid[p] & ~reset & ((cnt_q[p] < DEPTH_C) | pop[p]);
    end
  end

  // Round-robin arbitration; grant is only given to an eligible port, so grant == accept
  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant_q;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == LAST_P2) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[0]) begin
      last_grant_d = LAST_P1;
    end else if (grant[1]) begin
      last_grant_d = LAST_P2;
    end
  end

  assign req_ready_1    = grant[0];
  assign req_ready_2    = grant[1];
  assign res_in_valid_1 = grant[0];
  assign res_in_valid_2 = grant[1];
  assign res_input      = grant[0] ? req_data_1 : (grant[1] ? req_data_2 : '0);

`ifdef SHARED_ARB_CHECK_EN
  // issued_q marks an accept last cycle, i.e. a result expected this cycle
  logic [1:0] issued_q, issued_d;
  logic       err_q, err_d;

  // Result acceptance with issue tracking and sticky error detection
  always_comb begin
    issued_d = grant;
    err_d    = err_q | (|(res_out_valid & ~issued_q)) | (&res_out_valid);
    wr_en    = '0;
    for (int p = 0; p < 2; p++) begin
      wr_en[p] = res_out_valid[p] & issued_q[p] & (cnt_q[p] != '0) & ~reset;
    end
  end

  // Issue tracking and error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      err_q    <= 1'b0;
    end else begin
      issued_q <= issued_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  // Result acceptance: results with no outstanding credit (e.g. stale after reset) are dropped
  always_comb begin
    wr_en = '0;
    for (int p = 0; p < 2; p++) begin
      wr_en[p] = res_out_valid[p] & (cnt_q[p] != '0) & ~reset;
    end
  end
`endif

  // Credit counters and FIFO pointer/occupancy next state
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cnt_d[p]    = cnt_q[p];
      occ_d[p]    = occ_q[p];
      wr_ptr_d[p] = wr_ptr_q[p];
      rd_ptr_d[p] = rd_ptr_q[p];

      case ({grant[p], pop[p]})
        2'b10:   cnt_d[p] = cnt_q[p] + CNT_ONE;
        2'b01:   cnt_d[p] = cnt_q[p] - CNT_ONE;
        default: cnt_d[p] = cnt_q[p];
      endcase

      case ({wr_en[p], pop[p]})
        2'b10:   occ_d[p] = occ_q[p] + CNT_ONE;
        2'b01:   occ_d[p] = occ_q[p] - CNT_ONE;
        default: occ_d[p] = occ_q[p];
      endcase

      if (wr_en[p]) begin
        wr_ptr_d[p] = (wr_ptr_q[p] == PTR_LAST) ? '0 : wr_ptr_q[p] + PTR_ONE;
      end
      if (pop[p]) begin
        rd_ptr_d[p] = (rd_ptr_q[p] == PTR_LAST) ? '0 : rd_ptr_q[p] + PTR_ONE;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= LAST_P2;
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]    <= '0;
        occ_q[p]    <= '0;
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      for (int p = 0; p < 2; p++) begin
        cnt_q[p]    <= cnt_d[p];
        occ_q[p]    <= occ_d[p];
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy qualifies every read
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wr_en[p]) begin
        mem_q[p][wr_ptr_q[p]] <= res_output;
      end
    end
  end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter. It includes a model of the shared resource:
// the resource registers its input, so its output is 2x the input one cycle later,
// with per-port valid tags.
module tb_shared_resource_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_1, req_ready_1, req_valid_2, req_ready_2;
  logic [DW-1:0] req_data_1, req_data_2;
  logic          rsp_valid_1, rsp_ready_1, rsp_valid_2, rsp_ready_2;
  logic [DW-1:0] rsp_data_1, rsp_data_2;
  logic          res_in_valid_1, res_in_valid_2;
  logic [DW-1:0] res_input;
  logic          res_out_valid_1, res_out_valid_2;
  logic [DW-1:0] res_output;
`ifdef SHARED_ARB_CHECK_EN
  logic          err;
`endif

  logic          rov1_q = 1'b0, rov2_q = 1'b0;
  logic          force_ov1 = 1'b0, force_ov2 = 1'b0;
  logic [DW-1:0] rout_q = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rov1_q <= res_in_valid_1;
    rov2_q <= res_in_valid_2;
    rout_q <= res_input * 32'd2;
  end
  assign res_out_valid_1 = rov1_q | force_ov1;
  assign res_out_valid_2 = rov2_q | force_ov2;
  assign res_output      = rout_q;

  shared_resource_arbiter #(.DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
`ifdef SHARED_ARB_CHECK_EN
    .err(err),
`endif
    .clk(clk), .reset(reset),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_data_1(req_data_1),
    .req_valid_2(req_valid_2), .req_ready_2(req_ready_2), .req_data_2(req_data_2),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1),
    .rsp_valid_2(rsp_valid_2), .rsp_ready_2(rsp_ready_2), .rsp_data_2(rsp_data_2),
    .res_in_valid_1(res_in_valid_1), .res_in_valid_2(res_in_valid_2), .res_input(res_input),
    .res_out_valid_1(res_out_valid_1), .res_out_valid_2(res_out_valid_2), .res_output(res_output)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-port queue of accepted-but-not-popped results, each tagged with
  // the cycle its response becomes visible. Credit use is simply the queue length.
  typedef struct {
    logic [DW-1:0] val;
    int            due;
  } ent_t;
  ent_t q1[$];
  ent_t q2[$];
  int   last_m;
  int   ncyc;
  logic s_rdy1, s_rdy2, s_rv2;
  logic [DW-1:0] s_rsp2;

  task automatic clear_inputs();
    req_valid_1 = 0; req_valid_2 = 0; req_data_1 = '0; req_data_2 = '0;
    rsp_ready_1 = 0; rsp_ready_2 = 0;
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs(); force_ov1 = 0; force_ov2 = 0;
    step(); step();
    reset = 0;
    q1.delete(); q2.delete();
    last_m = 2; ncyc = 0;
  endtask

  task automatic model_cycle(input bit v1, input bit v2, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2, input bit r1, input bit r2);
    bit vis1, vis2, p1, p2, e1, e2, g1, g2;
    logic [DW-1:0] ed1, ed2, ein;
    ent_t e;
    req_valid_1 = v1; req_valid_2 = v2; req_data_1 = d1; req_data_2 = d2;
    rsp_ready_1 = r1; rsp_ready_2 = r2;
    vis1 = 0; vis2 = 0; ed1 = '0; ed2 = '0;
    if (q1.size() > 0) if (q1[0].due <= ncyc) begin vis1 = 1; ed1 = q1[0].val; end
    if (q2.size() > 0) if (q2[0].due <= ncyc) begin vis2 = 1; ed2 = q2[0].val; end
    p1 = vis1 & r1;
    p2 = vis2 & r2;
    e1 = v1 && ((q1.size() - int'(p1)) < DEPTH);
    e2 = v2 && ((q2.size() - int'(p2)) < DEPTH);
    g1 = 0; g2 = 0;
    if (e1 && e2) begin
      if (last_m == 2) g1 = 1; else g2 = 1;
    end else begin
      g1 = e1; g2 = e2;
    end
    ein = g1 ? d1 : (g2 ? d2 : '0);
    #3;
    chk("m_req_ready_1", req_ready_1, g1);
    chk("m_req_ready_2", req_ready_2, g2);
    chk("m_res_in_valid_1", res_in_valid_1, g1);
    chk("m_res_in_valid_2", res_in_valid_2, g2);
    chk("m_res_input", res_input, ein);
    chk("m_rsp_valid_1", rsp_valid_1, vis1);
    chk("m_rsp_valid_2", rsp_valid_2, vis2);
    chk("m_rsp_data_1", rsp_data_1, ed1);
    chk("m_rsp_data_2", rsp_data_2, ed2);
    s_rdy1 = req_ready_1; s_rdy2 = req_ready_2; s_rsp2 = rsp_data_2; s_rv2 = rsp_valid_2;
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (g1) begin e.val = d1 * 32'd2; e.due = ncyc + 2; q1.push_back(e); last_m = 1; end
    if (g2) begin e.val = d2 * 32'd2; e.due = ncyc + 2; q2.push_back(e); last_m = 2; end
    ncyc++;
    step();
  endtask

  typedef struct {
    int            prime;
    bit            v1, v2;
    logic [DW-1:0] d1, d2;
    bit            e_r1, e_r2;
    logic [DW-1:0] e_in;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    logic [DW-1:0] held;

    vecs[0] = '{0, 0, 0, 32'hA1, 32'hB2, 0, 0, 32'h0};
    vecs[1] = '{0, 1, 0, 32'h5,  32'hB2, 1, 0, 32'h5};
    vecs[2] = '{0, 0, 1, 32'hA1, 32'h7,  0, 1, 32'h7};
    vecs[3] = '{0, 1, 1, 32'hA1, 32'hB2, 1, 0, 32'hA1};
    vecs[4] = '{1, 1, 1, 32'hA1, 32'hB2, 0, 1, 32'hB2};
    vecs[5] = '{2, 1, 1, 32'hA1, 32'hB2, 1, 0, 32'hA1};
    vecs[6] = '{1, 1, 0, 32'hC3, 32'hB2, 1, 0, 32'hC3};
    vecs[7] = '{2, 0, 1, 32'hA1, 32'hD4, 0, 1, 32'hD4};

    // Reset state: outputs low even with requests pending during reset
    reset = 1;
    req_valid_1 = 1; req_valid_2 = 1; req_data_1 = 32'h12; req_data_2 = 32'h34;
    rsp_ready_1 = 1; rsp_ready_2 = 1;
    step(); step(); #3;
    chk("rst_req_ready_1", req_ready_1, 0);
    chk("rst_req_ready_2", req_ready_2, 0);
    chk("rst_rsp_valid_1", rsp_valid_1, 0);
    chk("rst_rsp_valid_2", rsp_valid_2, 0);
    chk("rst_rsp_data_1", rsp_data_1, 0);
    chk("rst_rsp_data_2", rsp_data_2, 0);
    chk("rst_res_in_valid_1", res_in_valid_1, 0);
    chk("rst_res_in_valid_2", res_in_valid_2, 0);
    chk("rst_res_input", res_input, 0);
`ifdef SHARED_ARB_CHECK_EN
    chk("rst_err", err, 0);
`endif

    // Arbitration table, each vector from a fresh reset and an optional priming accept
    for (int i = 0; i < 8; i++) begin
      do_reset();
      if (vecs[i].prime == 1) begin
        req_valid_1 = 1; req_data_1 = 32'h11; step(); req_valid_1 = 0;
      end else if (vecs[i].prime == 2) begin
        req_valid_2 = 1; req_data_2 = 32'h22; step(); req_valid_2 = 0;
      end
      req_valid_1 = vecs[i].v1; req_valid_2 = vecs[i].v2;
      req_data_1 = vecs[i].d1; req_data_2 = vecs[i].d2;
      #3;
      chk($sformatf("tbl%0d_req_ready_1", i), req_ready_1, vecs[i].e_r1);
      chk($sformatf("tbl%0d_req_ready_2", i), req_ready_2, vecs[i].e_r2);
      chk($sformatf("tbl%0d_res_in_valid_1", i), res_in_valid_1, vecs[i].e_r1);
      chk($sformatf("tbl%0d_res_in_valid_2", i), res_in_valid_2, vecs[i].e_r2);
      chk($sformatf("tbl%0d_res_input", i), res_input, vecs[i].e_in);
      step();
      clear_inputs();
    end

    // Single request on port 1: 0x5 in cycle 0, 0xA visible in cycle 2, held until popped
    do_reset();
    req_valid_1 = 1; req_data_1 = 32'h5; #3;
    chk("single_req_ready_1", req_ready_1, 1);
    chk("single_res_in_valid_1", res_in_valid_1, 1);
    chk("single_res_input", res_input, 32'h5);
    step(); req_valid_1 = 0; #3;
    chk("single_c1_rsp_valid_1", rsp_valid_1, 0);
    step(); #3;
    chk("single_c2_rsp_valid_1", rsp_valid_1, 1);
    chk("single_c2_rsp_data_1", rsp_data_1, 32'hA);
    step(); #3;
    chk("single_c3_rsp_data_1", rsp_data_1, 32'hA);
    rsp_ready_1 = 1;
    step(); #3;
    chk("single_popped_rsp_valid_1", rsp_valid_1, 0);

    // Tie: grants alternate starting with port 1; data wraps in the resource
    do_reset();
    for (int k = 0; k < 8; k++) begin
      model_cycle(1, 1, 32'h80000001, 32'h3, 1, 1);
      chk("tie_alt_grant_1", s_rdy1, (k % 2) == 0);
    end
    for (int k = 0; k < 3; k++) model_cycle(0, 0, '0, '0, 1, 1);

    // Backpressure on port 2: exactly two accepts, port 1 keeps going, head stays stable
    do_reset();
    a1 = 0; a2 = 0; held = '0;
    for (int k = 0; k < 12; k++) begin
      model_cycle(1, 1, $urandom, $urandom, 1, 0);
      a1 += int'(s_rdy1);
      a2 += int'(s_rdy2);
      if (k == 4) held = s_rsp2;
    end
    chk("bp_accepts_2", a2, 2);
    chk("bp_accepts_1", a1, 10);
    chk("bp_held_rsp_data_2", s_rsp2, held);
    for (int k = 0; k < 4; k++) model_cycle(0, 0, '0, '0, 1, 1);

    // Full FIFO: pop and accept in the same cycle keeps the credit count at the limit
    do_reset();
    req_valid_1 = 1; req_data_1 = 32'h100; step();
    req_data_1 = 32'h200; step();
    req_data_1 = 32'h300; #3;
    chk("full_no_credit_ready_1", req_ready_1, 0);
    step(); rsp_ready_1 = 1; #3;
    chk("full_pop_accept_ready_1", req_ready_1, 1);
    chk("full_pop_head_1", rsp_data_1, 32'h200);
    step(); rsp_ready_1 = 0; #3;
    chk("full_after_ready_1", req_ready_1, 0);
    chk("full_after_head_1", rsp_data_1, 32'h400);
    clear_inputs();

    // Reset in the cycle after an accept: stale result dropped, tie goes to port 1
    do_reset();
    req_valid_1 = 1; req_data_1 = 32'h55; rsp_ready_1 = 1; #3;
    chk("mid_accept_ready_1", req_ready_1, 1);
    step(); req_valid_1 = 0; reset = 1; #3;
    chk("mid_rst_res_in_valid_1", res_in_valid_1, 0);
    chk("mid_rst_res_input", res_input, 0);
    step(); reset = 0; #3;
    chk("mid_next_rsp_valid_1", rsp_valid_1, 0);
    chk("mid_next_rsp_data_1", rsp_data_1, 0);
    chk("mid_next_req_ready_1", req_ready_1, 0);
    for (int k = 0; k < 3; k++) begin
      step(); #3;
      chk("mid_stale_rsp_valid_1", rsp_valid_1, 0);
    end
    req_valid_1 = 1; req_valid_2 = 1; #3;
    chk("mid_tie_ready_1", req_ready_1, 1);
    chk("mid_tie_ready_2", req_ready_2, 0);
    step(); clear_inputs();

    // Spurious result on port 2 with no credit is never stored
    do_reset();
    force_ov2 = 1; #3;
    chk("spur_rsp_valid_2_c0", rsp_valid_2, 0);
    step(); force_ov2 = 0; #3;
    chk("spur_rsp_valid_2_c1", rsp_valid_2, 0);
`ifdef SHARED_ARB_CHECK_EN
    chk("spur_err_set", err, 1);
    for (int k = 0; k < 3; k++) begin
      step(); #3;
      chk("spur_err_held", err, 1);
      chk("spur_rsp_valid_2_held", rsp_valid_2, 0);
    end
`endif

    // Random traffic against the queue model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      model_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom, $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
    end
    for (int k = 0; k < 6; k++) model_cycle(0, 0, '0, '0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
